imem_loader: RTL

//  Writer side of the instruction memory that fetch reads: receives a program as a byte

---
 rtl/imem_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a length-prefixed byte stream, packs big-endian
// 32-bit words into consecutive imem addresses and holds the CPU in reset meanwhile.
module imem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_wren,
  output logic              cpu_rstd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned REM_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [REM_W-1:0] remaining;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] tcnt;
  logic             accept;
  logic             timeout_hit;

  assign accept      = in_valid & in_ready;
  assign timeout_hit = (tcnt == CNT_W'(TIMEOUT - 1));

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      im_wren      <= 1'b1;
      cpu_rstd     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      remaining    <= '0;
      byte_idx     <= '0;
      tcnt         <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            err          <= 1'b0;
            cpu_rstd     <= 1'b0;
            words_loaded <= '0;
            im_addr      <= '0;
            tcnt         <= '0;
          end else if (state == S_IDLE) begin
            cpu_rstd <= 1'b1;
          end
        end

        S_LEN: begin
          if (accept) begin
            remaining <= (in_data == 8'd0) ? REM_W'(256) : REM_W'(in_data);
            byte_idx  <= '0;
            tcnt      <= '0;
            state     <= S_DATA;
          end else if (timeout_hit) begin
            state    <= S_ERR;
            err      <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (accept) begin
            im_wdata <= {im_wdata[23:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            tcnt     <= '0;
            if (byte_idx == 2'd3) begin
              state    <= S_WRITE;
              in_ready <= 1'b0;
              im_wren  <= 1'b0;
            end
          end else if (timeout_hit) begin
            // A partially assembled word is dropped, never written.
            state    <= S_ERR;
            err      <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end

        S_WRITE: begin
          im_wren      <= 1'b1;
          im_addr      <= im_addr + ADDR_W'(1);
          words_loaded <= words_loaded + REM_W'(1);
          remaining    <= remaining - REM_W'(1);
          if (remaining == REM_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_DATA;
            in_ready <= 1'b1;
          end
        end

        S_DONE: begin
          done     <= 1'b0;
          cpu_rstd <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
